// File: rtl/tc_file_writer.sv
// Byte-addressed write capture memory with a valid/ready byte replay port.
// Bytes 0..length-1 are streamed on flush, one byte every two cycles.
module tc_file_writer #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  size,
  input  logic [63:0] address,
  input  logic [63:0] data_in,
  input  logic        flush,
  output logic        busy,
  output logic [63:0] length,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_last,
  input  logic        byte_ready
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } state_t;

  state_t        state;
  logic [7:0]    mem [MEM_BYTES];
  logic [63:0]   ptr;
  logic          idle;
  logic          trunc;
  logic          wr;
  logic [3:0]    nbytes;
  logic [64:0]   wr_end;
  logic [63:0]   wr_cap;
  logic [63:0]   new_len;
  logic [AW-1:0] base;

  assign base = address[AW-1:0];

  // Post-write length, so a flush on the same edge sees the new data.
  always_comb begin
    idle    = state == IDLE;
    trunc   = idle && en && (&address);
    wr      = idle && en && !(&address);
    nbytes  = 4'd1 << size;
    wr_end  = {1'b0, address} + {61'd0, nbytes};
    wr_cap  = (wr_end > 65'(MEM_BYTES)) ?
              64'(MEM_BYTES) : wr_end[63:0];
    new_len = length;
    if (trunc) begin
      new_len = '0;
    end else if (wr && wr_cap > length) begin
      new_len = wr_cap;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < nbytes) begin
          mem[base + AW'(i)] <= data_in[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      length     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_last  <= 1'b0;
      ptr        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          length <= new_len;
          if (flush && new_len != '0) begin
            ptr   <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          byte_data  <= mem[ptr[AW-1:0]];
          byte_last  <= ptr == length - 64'd1;
          byte_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (byte_ready) begin
            byte_valid <= 1'b0;
            if (byte_last) begin
              byte_last <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              ptr   <= ptr + 64'd1;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_file_writer.sv
// Directed bench for tc_file_writer on a 16-byte instance.
// A byte model tracks written bytes; streams are checked against it.
module tb_tc_file_writer;

  localparam int MB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  size = '0;
  logic [63:0] address = '0;
  logic [63:0] data_in = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [63:0] length;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  mdl [MB];
  bit          known [MB];
  logic [63:0] mlen = '0;

  tc_file_writer #(.MEM_BYTES(MB)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .size(size),
    .address(address),
    .data_in(data_in),
    .flush(flush),
    .busy(busy),
    .length(length),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_last(byte_last),
    .byte_ready(byte_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_write(input logic [1:0] s,
                             input logic [63:0] a,
                             input logic [63:0] d);
    logic [64:0] e;
    int n;
    int idx;
    if (a == '1) begin
      mlen = '0;
    end else begin
      n = 1 << s;
      for (int i = 0; i < n; i++) begin
        idx = int'((a + 64'(i)) % 64'(MB));
        mdl[idx] = d[8*i +: 8];
        known[idx] = 1'b1;
      end
      e = {1'b0, a} + 65'(n);
      if (e > 65'(MB)) e = 65'(MB);
      if (e[63:0] > mlen) mlen = e[63:0];
    end
  endtask

  task automatic drive_write(input logic [1:0] s,
                             input logic [63:0] a,
                             input logic [63:0] d,
                             input bit fl);
    @(negedge clk);
    en = 1'b1;
    size = s;
    address = a;
    data_in = d;
    flush = fl;
    model_write(s, a, d);
    @(negedge clk);
    en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic collect(input string tag, input bit rnd, input int abort_at);
    int got = 0;
    int busy_n = 0;
    bit done = 0;
    bit stalled = 0;
    bit aborted = 0;
    logic [7:0] held = '0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (c == 0) chk({tag, "_start"}, {62'd0, busy, byte_valid}, 64'd2);
      if (busy) busy_n++;
      if (abort_at >= 0 && got == abort_at && byte_valid) begin
        rst = 1'b0;
        #1;
        chk({tag, "_rst_flags"},
            {61'd0, busy, byte_valid, byte_last}, 64'd0);
        chk({tag, "_rst_data"}, {56'd0, byte_data}, 64'd0);
        chk({tag, "_rst_len"}, length, 64'd0);
        mlen = '0;
        aborted = 1'b1;
        done = 1'b1;
      end else begin
        if (byte_valid && stalled)
          chk({tag, "_hold"}, {56'd0, byte_data}, {56'd0, held});
        byte_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        stalled = 1'b0;
        if (byte_valid) begin
          if (byte_ready) begin
            if (got < MB && known[got])
              chk($sformatf("%s_b%0d", tag, got),
                  {56'd0, byte_data}, {56'd0, mdl[got]});
            chk($sformatf("%s_last%0d", tag, got),
                {63'd0, byte_last}, {63'd0, 64'(got) == mlen - 64'd1});
            got++;
            if (byte_last) done = 1'b1;
          end else begin
            stalled = 1'b1;
            held = byte_data;
          end
        end
      end
      @(negedge clk);
    end
    byte_ready = 1'b0;
    if (!done) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else if (!aborted) begin
      chk({tag, "_count"}, 64'(got), mlen);
      if (!rnd) chk({tag, "_busy_cyc"}, 64'(busy_n), 2 * mlen);
      chk({tag, "_end"}, {61'd0, busy, byte_valid, byte_last}, 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < MB; i++) begin
      mdl[i] = '0;
      known[i] = 1'b0;
    end
    #12;
    chk("rst_flags", {61'd0, busy, byte_valid, byte_last}, 64'd0);
    chk("rst_data", {56'd0, byte_data}, 64'd0);
    chk("rst_len", length, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    drive_write(2'd3, 64'd0, 64'h8877665544332211, 1'b0);
    chk("w8_len", length, 64'd8);
    do_flush();
    collect("f8", 1'b0, -1);

    drive_write(2'd0, '1, 64'h0, 1'b0);
    chk("trunc1_len", length, 64'd0);
    drive_write(2'd0, 64'd5, 64'hAA, 1'b0);
    chk("w1_len", length, 64'd6);
    do_flush();
    collect("f6", 1'b0, -1);

    drive_write(2'd3, '1, 64'h1234, 1'b0);
    chk("trunc2_len", length, 64'd0);
    do_flush();
    for (int i = 0; i < 4; i++) begin
      chk("empty_flush", {62'd0, busy, byte_valid}, 64'd0);
      @(negedge clk);
    end

    drive_write(2'd3, 64'd0, 64'h8877665544332211, 1'b0);
    drive_write(2'd3, 64'd8, 64'h0123456789ABCDEF, 1'b0);
    chk("bp_len", length, 64'd16);
    do_flush();
    collect("fbp", 1'b1, -1);

    drive_write(2'd0, '1, 64'h0, 1'b0);
    drive_write(2'd2, 64'd14, 64'hDDCCBBAA, 1'b0);
    chk("wrap_len", length, 64'd16);
    chk("wrap_m0", {56'd0, mdl[0]}, 64'hCC);
    do_flush();
    collect("fwrap", 1'b0, -1);

    drive_write(2'd0, '1, 64'h0, 1'b0);
    drive_write(2'd1, 64'd0, 64'hBEEF, 1'b1);
    chk("sim_len", length, 64'd2);
    collect("fsim", 1'b0, -1);
    drive_write(2'd0, '1, 64'h55, 1'b0);
    chk("trunc3_len", length, 64'd0);

    drive_write(2'd0, 64'h21, 64'h77, 1'b0);
    chk("far_len", length, 64'd16);
    drive_write(2'd0, '1, 64'h0, 1'b0);

    drive_write(2'd3, 64'd0, 64'hF0E0D0C0B0A09080, 1'b0);
    chk("ab_len", length, 64'd8);
    do_flush();
    collect("fab", 1'b0, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_len", length, 64'd0);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    drive_write(2'd0, 64'd7, 64'h5A, 1'b0);
    chk("rewr_len", length, 64'd8);
    do_flush();
    collect("frewr", 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
